// File: rtl/shiftrows_sequencer.sv
// Cycle sequencer for the 8-bit ShiftRows permutation unit: accepts gap-free 16-byte
// blocks, schedules the tap select c3 and output framing LAT cycles behind the input.
//
// state   | meaning
// S_IDLE  | no block in flight, waiting for byte 0
// S_RUN   | accepting a block; every cycle must carry a byte
// S_DRAIN | input closed, flushing tokens of complete blocks
module shiftrows_sequencer #(
    parameter int          LAT     = 12,
    parameter logic [31:0] SEL_LUT = 32'h000424E4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       blk_last,
    input  logic       sr_en,
    output logic [1:0] c3,
    output logic       out_valid,
    output logic       out_first,
    output logic       out_last,
    output logic       busy,
    output logic       err_underrun
);

    localparam int DL = LAT - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_in_ptr;
    logic          r_sr_lat;
    logic          r_err;
    logic [DL-1:0] r_dl_vld;
    logic [DL-1:0] r_dl_sr;
    logic [3:0]    r_dl_k [DL];
    logic [1:0]    r_c3;
    logic          r_out_valid;
    logic          r_out_first;
    logic          r_out_last;

    logic          w_accept;
    logic          w_underrun;
    logic          w_tok_sr;
    logic          w_emit;
    logic [1:0]    w_slot_c3;
    logic [DL-1:0] w_kill;

    assign w_accept   = in_valid & in_ready;
    assign w_underrun = (r_state == S_RUN) & ~in_valid;
    assign w_tok_sr   = (r_in_ptr == 4'd0) ? sr_en : r_sr_lat;

    // The partial block's tokens are the r_in_ptr most recent entries of the line.
    always_comb begin
        w_kill = '0;
        for (int i = 0; i < DL; i++) begin
            if (w_underrun && (i < int'(r_in_ptr))) begin
                w_kill[i] = 1'b1;
            end
        end
    end

    assign w_emit    = r_dl_vld[DL-1] & ~w_kill[DL-1];
    assign w_slot_c3 = SEL_LUT[{r_dl_k[DL-1], 1'b0} +: 2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                if (!in_valid) begin
                    w_next = S_DRAIN;
                end else if ((r_in_ptr == 4'd15) && blk_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!(|r_dl_vld)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state != S_DRAIN);
        busy     = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ptr <= 4'd0;
            r_sr_lat <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_underrun) begin
                r_in_ptr <= 4'd0;
                r_err    <= 1'b1;
            end else if (w_accept) begin
                r_in_ptr <= r_in_ptr + 4'd1;
            end
            if (w_accept && (r_in_ptr == 4'd0)) begin
                r_sr_lat <= sr_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_vld <= '0;
            r_dl_sr  <= '0;
            for (int i = 0; i < DL; i++) begin
                r_dl_k[i] <= 4'd0;
            end
        end else begin
            r_dl_vld[0] <= w_accept;
            r_dl_sr[0]  <= w_tok_sr;
            r_dl_k[0]   <= r_in_ptr;
            for (int i = 1; i < DL; i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1] & ~w_kill[i-1];
                r_dl_sr[i]  <= r_dl_sr[i-1];
                r_dl_k[i]   <= r_dl_k[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c3        <= 2'b00;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_valid <= w_emit;
            r_out_first <= w_emit & (r_dl_k[DL-1] == 4'd0);
            r_out_last  <= w_emit & (r_dl_k[DL-1] == 4'd15);
            r_c3        <= (w_emit && r_dl_sr[DL-1]) ? w_slot_c3 : 2'b00;
        end
    end

    assign c3           = r_c3;
    assign out_valid    = r_out_valid;
    assign out_first    = r_out_first;
    assign out_last     = r_out_last;
    assign err_underrun = r_err;

endmodule

// File: tb/tb_shiftrows_sequencer.sv
// Directed bench for shiftrows_sequencer: per-slot expectation tables plus
// hand-written reset, underrun and drain sequences.
module tb_shiftrows_sequencer;

    typedef struct {
        int         k;
        logic [1:0] c3;
        logic       first;
        logic       last;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [1:0] c3;
        logic       first;
        logic       last;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       blk_last = 1'b0;
    logic       sr_en = 1'b0;
    logic       in_ready;
    logic [1:0] c3;
    logic       out_valid;
    logic       out_first;
    logic       out_last;
    logic       busy;
    logic       err_underrun;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    obs_t q[$];
    vec_t vecs[$];

    // Expected c3 per slot when sr_en=1, hand-written from the ShiftRows pattern.
    logic [1:0] C3_SR [16] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0,
                               2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

    shiftrows_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .blk_last     (blk_last),
        .sr_en        (sr_en),
        .c3           (c3),
        .out_valid    (out_valid),
        .out_first    (out_first),
        .out_last     (out_last),
        .busy         (busy),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            q.push_back('{cyc: cyc, c3: c3, first: out_first, last: out_last});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic l, input logic s);
        in_valid = v;
        blk_last = l;
        sr_en    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic s, input logic l, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            step(1'b1, l && (i == 15), s);
        end
    endtask

    task automatic add_block(input logic s);
        for (int k = 0; k < 16; k++) begin
            vecs.push_back('{k: k, c3: (s ? C3_SR[k] : 2'd0),
                             first: (k == 0), last: (k == 15)});
        end
    endtask

    task automatic wait_idle(input string name, input int max, output int fall);
        fall = -1;
        for (int i = 0; i < max; i++) begin
            if (!busy) begin
                fall = cyc;
                break;
            end
            step(1'b0, 1'b0, 1'b0);
        end
        if (fall < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_idle_timeout: busy still 1 after %0d cycles", name, max);
        end
    endtask

    task automatic check_slots(input string name, input int t0);
        chk({name, "_nslots"}, q.size(), vecs.size());
        for (int j = 0; j < vecs.size() && j < q.size(); j++) begin
            chk($sformatf("%s_cyc%0d", name, j),   q[j].cyc - t0, 12 + j);
            chk($sformatf("%s_c3_%0d", name, j),   q[j].c3,       vecs[j].c3);
            chk($sformatf("%s_first%0d", name, j), q[j].first,    vecs[j].first);
            chk($sformatf("%s_last%0d", name, j),  q[j].last,     vecs[j].last);
        end
    endtask

    initial begin
        int t0;
        int fall;

        // 1: reset held with in_valid high
        rst_n    = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_c3",        c3,           0);
        chk("rst_out_valid", out_valid,    0);
        chk("rst_busy",      busy,         0);
        chk("rst_in_ready",  in_ready,     1);
        chk("rst_err",       err_underrun, 0);
        in_valid = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2: single block, sr_en=1
        q.delete();
        vecs.delete();
        add_block(1'b1);
        t0 = cyc;
        send_block(1'b1, 1'b1, 16);
        wait_idle("single", 60, fall);
        chk("single_busy_fall", fall - t0, 28);
        check_slots("single", t0);
        chk("single_err", err_underrun, 0);

        // 3: three back-to-back blocks, middle one pass-through
        q.delete();
        vecs.delete();
        add_block(1'b1);
        add_block(1'b0);
        add_block(1'b1);
        t0 = cyc;
        send_block(1'b1, 1'b0, 16);
        send_block(1'b0, 1'b0, 16);
        send_block(1'b1, 1'b1, 16);
        wait_idle("b2b", 80, fall);
        chk("b2b_busy_fall", fall - t0, 60);
        check_slots("b2b", t0);

        // 4: underrun at byte 7 of the second block
        q.delete();
        vecs.delete();
        add_block(1'b1);
        t0 = cyc;
        send_block(1'b1, 1'b0, 16);
        send_block(1'b1, 1'b0, 7);
        chk("urun_err_before", err_underrun, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("urun_err_next", err_underrun, 1);
        chk("urun_busy_drain", busy, 1);
        wait_idle("urun", 60, fall);
        chk("urun_busy_fall", fall - t0, 28);
        chk("urun_in_ready", in_ready, 1);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        check_slots("urun", t0);
        chk("urun_err_sticky", err_underrun, 1);

        // 5: async reset pulse at byte 9 of a follow-on block
        q.delete();
        t0 = cyc;
        send_block(1'b1, 1'b0, 16);
        send_block(1'b1, 1'b0, 9);
        chk("arst_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_c3",        c3,        0);
        chk("arst_busy",      busy,      0);
        chk("arst_err",       err_underrun, 0);
        chk("arst_in_ready",  in_ready,  1);
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        repeat (20) step(1'b0, 1'b0, 1'b0);
        chk("arst_quiet", q.size(), 0);
        chk("arst_quiet_busy", busy, 0);
        vecs.delete();
        add_block(1'b1);
        t0 = cyc;
        send_block(1'b1, 1'b1, 16);
        wait_idle("arst", 60, fall);
        check_slots("arst", t0);

        // 6: in_valid asserted while draining
        q.delete();
        vecs.delete();
        add_block(1'b0);
        t0 = cyc;
        send_block(1'b0, 1'b1, 16);
        chk("drain_in_ready", in_ready, 0);
        repeat (8) step(1'b1, 1'b1, 1'b1);
        chk("drain_in_ready_late", in_ready, 0);
        wait_idle("drain", 60, fall);
        chk("drain_busy_fall", fall - t0, 28);
        repeat (20) step(1'b0, 1'b0, 1'b0);
        check_slots("drain", t0);
        chk("drain_err", err_underrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
